// File: rtl/ctrl_alu_unit.sv
// ctrl_alu_unit
// Decode, hazard and execute-control block for a 5-stage MIPS-subset pipeline.
// Decodes the instruction sitting in ID, produces operand forwarding selects,
// load-use and self-modifying-code stalls, branch/jump redirects, holds the
// ID/EX control register and contains the EX-stage ALU.
//
// Ports:
//   clock, reset        pipeline clock, synchronous active-high reset
//   IDIR, IDEQU         ID instruction, rs==rt comparison from the datapath
//   IFPC, IDPC          PCs of the IF and ID instructions
//   MEDES, MWREG,       MEM-stage destination, write-enable and load flag
//   MM2REG
//   EXA, EXB            EX operands as muxed by the datapath
//   WREG..JAL, ALUC     decoded ID controls (combinational)
//   FWDA, FWDB          rs/rt forwarding selects
//   WPCIR               stall: hold PC and IF/ID
//   BRANCH              redirect PC to branch/jump target
//   SMC, SMC2           EX store overwrites the ID / IF instruction
//   EXALU               ALU result
//   EXDES, EWREG,       registered ID/EX controls
//   EM2REG, EWMEM,
//   EALUIMM, ESHIFT,
//   EALUC
module ctrl_alu_unit (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] IDIR,
  input  logic        IDEQU,
  input  logic [31:0] IFPC,
  input  logic [31:0] IDPC,
  input  logic [4:0]  MEDES,
  input  logic        MWREG,
  input  logic        MM2REG,
  input  logic [31:0] EXA,
  input  logic [31:0] EXB,
  output logic        WREG,
  output logic        M2REG,
  output logic        WMEM,
  output logic        ALUIMM,
  output logic        SHIFT,
  output logic        SEXT,
  output logic        REGRT,
  output logic        JUMP,
  output logic        JR,
  output logic        JAL,
  output logic [3:0]  ALUC,
  output logic [1:0]  FWDA,
  output logic [1:0]  FWDB,
  output logic        WPCIR,
  output logic        BRANCH,
  output logic        SMC,
  output logic        SMC2,
  output logic [31:0] EXALU,
  output logic [4:0]  EXDES,
  output logic        EWREG,
  output logic        EM2REG,
  output logic        EWMEM,
  output logic        EALUIMM,
  output logic        ESHIFT,
  output logic [3:0]  EALUC
);

  typedef enum logic [3:0] {
    ALU_ADD = 4'd0,
    ALU_SUB = 4'd1,
    ALU_AND = 4'd2,
    ALU_OR  = 4'd3,
    ALU_XOR = 4'd4,
    ALU_LUI = 4'd5,
    ALU_SLL = 4'd6,
    ALU_SRL = 4'd7,
    ALU_SRA = 4'd8,
    ALU_SLT = 4'd9
  } aluOp_e;

  // Instruction fields
  logic [5:0] opcode;
  logic [5:0] funct;
  logic [4:0] rs;
  logic [4:0] rt;
  logic [4:0] rd;
  logic       unusedShamt;

  assign opcode      = IDIR[31:26];
  assign rs          = IDIR[25:21];
  assign rt          = IDIR[20:16];
  assign rd          = IDIR[15:11];
  assign funct       = IDIR[5:0];
  // shamt reaches the ALU through the datapath, not through this block
  assign unusedShamt = ^IDIR[10:6];

  // Decoded (unmasked) controls
  logic       wregRaw;
  logic       m2regDec;
  logic       wmemDec;
  logic       aluimmDec;
  logic       shiftDec;
  logic       sextDec;
  logic       regrtDec;
  logic       jumpDec;
  logic       jrDec;
  logic       jalDec;
  logic       isBeq;
  logic       isBne;
  logic       useRs;
  logic       useRt;
  aluOp_e     alucDec;
  logic [4:0] destReg;

  // Main decoder: every unsupported encoding falls through to the all-zero
  // defaults, which behaves as a NOP.
  always_comb begin
    wregRaw   = 1'b0;
    m2regDec  = 1'b0;
    wmemDec   = 1'b0;
    aluimmDec = 1'b0;
    shiftDec  = 1'b0;
    sextDec   = 1'b0;
    regrtDec  = 1'b0;
    jumpDec   = 1'b0;
    jrDec     = 1'b0;
    jalDec    = 1'b0;
    isBeq     = 1'b0;
    isBne     = 1'b0;
    useRs     = 1'b0;
    useRt     = 1'b0;
    alucDec   = ALU_ADD;
    case (opcode)
      6'h00: begin
        case (funct)
          6'h20: begin wregRaw = 1'b1; useRs = 1'b1; useRt = 1'b1; alucDec = ALU_ADD; end
          6'h22: begin wregRaw = 1'b1; useRs = 1'b1; useRt = 1'b1; alucDec = ALU_SUB; end
          6'h24: begin wregRaw = 1'b1; useRs = 1'b1; useRt = 1'b1; alucDec = ALU_AND; end
          6'h25: begin wregRaw = 1'b1; useRs = 1'b1; useRt = 1'b1; alucDec = ALU_OR;  end
          6'h26: begin wregRaw = 1'b1; useRs = 1'b1; useRt = 1'b1; alucDec = ALU_XOR; end
          6'h2A: begin wregRaw = 1'b1; useRs = 1'b1; useRt = 1'b1; alucDec = ALU_SLT; end
          // Shifts take shamt as A, so rs is not a source
          6'h00: begin wregRaw = 1'b1; shiftDec = 1'b1; useRt = 1'b1; alucDec = ALU_SLL; end
          6'h02: begin wregRaw = 1'b1; shiftDec = 1'b1; useRt = 1'b1; alucDec = ALU_SRL; end
          6'h03: begin wregRaw = 1'b1; shiftDec = 1'b1; useRt = 1'b1; alucDec = ALU_SRA; end
          6'h08: begin jrDec = 1'b1; useRs = 1'b1; useRt = 1'b1; end
          default: ;
        endcase
      end
      6'h08: begin wregRaw = 1'b1; aluimmDec = 1'b1; regrtDec = 1'b1; useRs = 1'b1; alucDec = ALU_ADD; end
      6'h0A: begin wregRaw = 1'b1; aluimmDec = 1'b1; regrtDec = 1'b1; useRs = 1'b1; alucDec = ALU_SLT; end
      // Logical immediates are zero-extended (SEXT high selects zero-extension)
      6'h0C: begin
        wregRaw = 1'b1; aluimmDec = 1'b1; regrtDec = 1'b1; useRs = 1'b1;
        sextDec = 1'b1; alucDec = ALU_AND;
      end
      6'h0D: begin
        wregRaw = 1'b1; aluimmDec = 1'b1; regrtDec = 1'b1; useRs = 1'b1;
        sextDec = 1'b1; alucDec = ALU_OR;
      end
      6'h0E: begin
        wregRaw = 1'b1; aluimmDec = 1'b1; regrtDec = 1'b1; useRs = 1'b1;
        sextDec = 1'b1; alucDec = ALU_XOR;
      end
      6'h0F: begin wregRaw = 1'b1; aluimmDec = 1'b1; regrtDec = 1'b1; alucDec = ALU_LUI; end
      6'h23: begin
        wregRaw = 1'b1; m2regDec = 1'b1; aluimmDec = 1'b1; regrtDec = 1'b1;
        useRs = 1'b1; alucDec = ALU_ADD;
      end
      6'h2B: begin wmemDec = 1'b1; aluimmDec = 1'b1; useRs = 1'b1; useRt = 1'b1; alucDec = ALU_ADD; end
      6'h04: begin isBeq = 1'b1; useRs = 1'b1; useRt = 1'b1; end
      6'h05: begin isBne = 1'b1; useRs = 1'b1; useRt = 1'b1; end
      6'h02: begin jumpDec = 1'b1; end
      // jal writes the return address via an add with B forced to 0 by the datapath
      6'h03: begin jumpDec = 1'b1; jalDec = 1'b1; wregRaw = 1'b1; alucDec = ALU_ADD; end
      default: ;
    endcase
  end

  assign destReg = jalDec ? 5'd31 : (regrtDec ? rt : rd);

  assign WREG   = wregRaw & (destReg != 5'd0);
  assign M2REG  = m2regDec;
  assign WMEM   = wmemDec;
  assign ALUIMM = aluimmDec;
  assign SHIFT  = shiftDec;
  assign SEXT   = sextDec;
  assign REGRT  = regrtDec;
  assign JUMP   = jumpDec;
  assign JR     = jrDec;
  assign JAL    = jalDec;
  assign ALUC   = alucDec;

  // Forwarding select for one source; the younger EX result wins over MEM.
  // A load in EX cannot forward, that case is handled by the stall instead.
  function automatic logic [1:0] fwdSel(
    input logic       used,
    input logic [4:0] src,
    input logic       exWreg,
    input logic       exM2reg,
    input logic [4:0] exDes,
    input logic       memWreg,
    input logic       memM2reg,
    input logic [4:0] memDes
  );
    logic [1:0] sel;
    sel = 2'b00;
    if (used && (src != 5'd0)) begin
      if (exWreg && !exM2reg && (exDes == src)) begin
        sel = 2'b01;
      end else if (memWreg && memM2reg && (memDes == src)) begin
        sel = 2'b11;
      end else if (memWreg && !memM2reg && (memDes == src)) begin
        sel = 2'b10;
      end
    end
    return sel;
  endfunction

  assign FWDA = fwdSel(useRs, rs, EWREG, EM2REG, EXDES, MWREG, MM2REG, MEDES);
  assign FWDB = fwdSel(useRt, rt, EWREG, EM2REG, EXDES, MWREG, MM2REG, MEDES);

  // Hazard detection: load-use and a store in EX hitting the ID instruction
  // both hold the front end; a store hitting IF is handled by the fetch path.
  logic loadUse;
  logic smcId;
  logic smcIf;

  always_comb begin
    loadUse = 1'b0;
    if (EWREG && EM2REG && (EXDES != 5'd0)) begin
      loadUse = (useRs && (EXDES == rs)) || (useRt && (EXDES == rt));
    end
  end

  assign smcId  = EWMEM & (EXALU == IDPC);
  assign smcIf  = EWMEM & (EXALU == IFPC);
  assign SMC    = smcId;
  assign SMC2   = smcIf;
  assign WPCIR  = loadUse | smcId;
  assign BRANCH = ~WPCIR & ((isBeq & IDEQU) | (isBne & ~IDEQU) | jumpDec | jrDec);

  // ID/EX control register next state: a stall turns the loaded
  // instruction into a bubble by killing its side effects.
  logic [4:0] exDes_d,   exDes_q;
  logic       ewreg_d,   ewreg_q;
  logic       em2reg_d,  em2reg_q;
  logic       ewmem_d,   ewmem_q;
  logic       ealuimm_d, ealuimm_q;
  logic       eshift_d,  eshift_q;
  logic [3:0] ealuc_d,   ealuc_q;

  always_comb begin
    exDes_d   = destReg;
    ewreg_d   = WREG & ~WPCIR;
    em2reg_d  = m2regDec & ~WPCIR;
    ewmem_d   = wmemDec & ~WPCIR;
    ealuimm_d = aluimmDec;
    eshift_d  = shiftDec;
    ealuc_d   = alucDec;
  end

  // ID/EX register loads every cycle, stall or not; reset discards it.
  always_ff @(posedge clock) begin
    if (reset) begin
      exDes_q   <= 5'd0;
      ewreg_q   <= 1'b0;
      em2reg_q  <= 1'b0;
      ewmem_q   <= 1'b0;
      ealuimm_q <= 1'b0;
      eshift_q  <= 1'b0;
      ealuc_q   <= 4'd0;
    end else begin
      exDes_q   <= exDes_d;
      ewreg_q   <= ewreg_d;
      em2reg_q  <= em2reg_d;
      ewmem_q   <= ewmem_d;
      ealuimm_q <= ealuimm_d;
      eshift_q  <= eshift_d;
      ealuc_q   <= ealuc_d;
    end
  end

  assign EXDES   = exDes_q;
  assign EWREG   = ewreg_q;
  assign EM2REG  = em2reg_q;
  assign EWMEM   = ewmem_q;
  assign EALUIMM = ealuimm_q;
  assign ESHIFT  = eshift_q;
  assign EALUC   = ealuc_q;

  // EX-stage ALU; unused op codes produce 0, arithmetic wraps silently.
  always_comb begin
    EXALU = 32'd0;
    case (ealuc_q)
      ALU_ADD: EXALU = EXA + EXB;
      ALU_SUB: EXALU = EXA - EXB;
      ALU_AND: EXALU = EXA & EXB;
      ALU_OR:  EXALU = EXA | EXB;
      ALU_XOR: EXALU = EXA ^ EXB;
      ALU_LUI: EXALU = {EXB[15:0], 16'h0000};
      ALU_SLL: EXALU = EXB << EXA[4:0];
      ALU_SRL: EXALU = EXB >> EXA[4:0];
      ALU_SRA: EXALU = $unsigned($signed(EXB) >>> EXA[4:0]);
      ALU_SLT: EXALU = {31'd0, ($signed(EXA) < $signed(EXB))};
      default: EXALU = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_ctrl_alu_unit.sv
// tb_ctrl_alu_unit
// Directed bench for ctrl_alu_unit. Stimulus pushes hand-computed expected
// values tagged with the cycle they belong to; a monitor on the falling edge
// pops and compares them against the DUT outputs.
module tb_ctrl_alu_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] IDIR;
  logic        IDEQU;
  logic [31:0] IFPC;
  logic [31:0] IDPC;
  logic [4:0]  MEDES;
  logic        MWREG;
  logic        MM2REG;
  logic [31:0] EXA;
  logic [31:0] EXB;
  logic        WREG, M2REG, WMEM, ALUIMM, SHIFT, SEXT, REGRT, JUMP, JR, JAL;
  logic [3:0]  ALUC;
  logic [1:0]  FWDA, FWDB;
  logic        WPCIR, BRANCH, SMC, SMC2;
  logic [31:0] EXALU;
  logic [4:0]  EXDES;
  logic        EWREG, EM2REG, EWMEM, EALUIMM, ESHIFT;
  logic [3:0]  EALUC;

  ctrl_alu_unit dut (
    .clock(clock), .reset(reset), .IDIR(IDIR), .IDEQU(IDEQU),
    .IFPC(IFPC), .IDPC(IDPC), .MEDES(MEDES), .MWREG(MWREG), .MM2REG(MM2REG),
    .EXA(EXA), .EXB(EXB),
    .WREG(WREG), .M2REG(M2REG), .WMEM(WMEM), .ALUIMM(ALUIMM), .SHIFT(SHIFT),
    .SEXT(SEXT), .REGRT(REGRT), .JUMP(JUMP), .JR(JR), .JAL(JAL), .ALUC(ALUC),
    .FWDA(FWDA), .FWDB(FWDB), .WPCIR(WPCIR), .BRANCH(BRANCH), .SMC(SMC),
    .SMC2(SMC2), .EXALU(EXALU), .EXDES(EXDES), .EWREG(EWREG), .EM2REG(EM2REG),
    .EWMEM(EWMEM), .EALUIMM(EALUIMM), .ESHIFT(ESHIFT), .EALUC(EALUC)
  );

  always #5 clock = ~clock;

  localparam int S_WREG = 0, S_M2REG = 1, S_WMEM = 2, S_ALUIMM = 3, S_SHIFT = 4;
  localparam int S_SEXT = 5, S_REGRT = 6, S_JUMP = 7, S_JR = 8, S_JAL = 9;
  localparam int S_ALUC = 10, S_FWDA = 11, S_FWDB = 12, S_WPCIR = 13, S_BRANCH = 14;
  localparam int S_SMC = 15, S_SMC2 = 16, S_EXALU = 17, S_EXDES = 18, S_EWREG = 19;
  localparam int S_EM2REG = 20, S_EWMEM = 21, S_EALUIMM = 22, S_ESHIFT = 23, S_EALUC = 24;

  typedef struct {
    int          cyc;
    string       name;
    int          sel;
    logic [31:0] exp;
  } expect_t;

  expect_t scoreQ[$];
  int cycleCount  = 0;
  int testsRun    = 0;
  int testsFailed = 0;

  always @(posedge clock) cycleCount <= cycleCount + 1;

  function automatic logic [31:0] getSig(input int sel);
    case (sel)
      S_WREG:    return {31'd0, WREG};
      S_M2REG:   return {31'd0, M2REG};
      S_WMEM:    return {31'd0, WMEM};
      S_ALUIMM:  return {31'd0, ALUIMM};
      S_SHIFT:   return {31'd0, SHIFT};
      S_SEXT:    return {31'd0, SEXT};
      S_REGRT:   return {31'd0, REGRT};
      S_JUMP:    return {31'd0, JUMP};
      S_JR:      return {31'd0, JR};
      S_JAL:     return {31'd0, JAL};
      S_ALUC:    return {28'd0, ALUC};
      S_FWDA:    return {30'd0, FWDA};
      S_FWDB:    return {30'd0, FWDB};
      S_WPCIR:   return {31'd0, WPCIR};
      S_BRANCH:  return {31'd0, BRANCH};
      S_SMC:     return {31'd0, SMC};
      S_SMC2:    return {31'd0, SMC2};
      S_EXALU:   return EXALU;
      S_EXDES:   return {27'd0, EXDES};
      S_EWREG:   return {31'd0, EWREG};
      S_EM2REG:  return {31'd0, EM2REG};
      S_EWMEM:   return {31'd0, EWMEM};
      S_EALUIMM: return {31'd0, EALUIMM};
      S_ESHIFT:  return {31'd0, ESHIFT};
      S_EALUC:   return {28'd0, EALUC};
      default:   return 32'hDEAD_BEEF;
    endcase
  endfunction

  // Queue an expectation for the current cycle
  task automatic expectVal(input string name, input int sel, input logic [31:0] value);
    expect_t e;
    e.cyc  = cycleCount;
    e.name = name;
    e.sel  = sel;
    e.exp  = value;
    scoreQ.push_back(e);
  endtask

  task automatic checkOutput(input expect_t e);
    logic [31:0] act;
    act = getSig(e.sel);
    testsRun++;
    if (act !== e.exp) begin
      testsFailed++;
      $display("[TB] FAIL %s (cycle %0d): got 0x%08h, expected 0x%08h",
               e.name, e.cyc, act, e.exp);
    end
  endtask

  // Monitor: compare everything due by this cycle, away from the rising edge
  initial begin
    expect_t e;
    forever begin
      @(negedge clock);
      while (scoreQ.size() > 0 && scoreQ[0].cyc <= cycleCount) begin
        e = scoreQ.pop_front();
        checkOutput(e);
      end
    end
  end

  task automatic nextCycle();
    @(posedge clock);
    #1;
  endtask

  task automatic applyStimulus(input logic [31:0] instr, input logic equ);
    IDIR  = instr;
    IDEQU = equ;
  endtask

  initial begin
    reset  = 1'b1;
    IDIR   = 32'h8C03_0000;
    IDEQU  = 1'b0;
    IFPC   = 32'h0000_0100;
    IDPC   = 32'h0000_00FC;
    MEDES  = 5'd0;
    MWREG  = 1'b0;
    MM2REG = 1'b0;
    EXA    = 32'd0;
    EXB    = 32'd0;

    // Reset has priority over loading a decoded lw
    nextCycle();
    nextCycle();
    expectVal("rst_ewreg", S_EWREG, 0);
    expectVal("rst_em2reg", S_EM2REG, 0);
    expectVal("rst_ealuimm", S_EALUIMM, 0);
    expectVal("rst_exdes", S_EXDES, 0);
    reset = 1'b0;
    applyStimulus(32'h0000_0000, 1'b0);

    // addi r1,r0,5
    nextCycle();
    applyStimulus(32'h2001_0005, 1'b0);
    expectVal("addi_wreg", S_WREG, 1);
    expectVal("addi_aluimm", S_ALUIMM, 1);
    expectVal("addi_regrt", S_REGRT, 1);
    expectVal("addi_sext", S_SEXT, 0);
    expectVal("addi_aluc", S_ALUC, 0);
    expectVal("addi_fwda", S_FWDA, 0);

    // add r2,r1,r1 with addi in EX
    nextCycle();
    applyStimulus(32'h0021_1020, 1'b0);
    EXA = 32'd5;
    EXB = 32'd5;
    expectVal("add_fwda", S_FWDA, 1);
    expectVal("add_fwdb", S_FWDB, 1);
    expectVal("add_exdes", S_EXDES, 1);
    expectVal("add_ewreg", S_EWREG, 1);
    expectVal("add_ealuc", S_EALUC, 0);
    expectVal("add_exalu", S_EXALU, 10);
    expectVal("add_wpcir", S_WPCIR, 0);

    // lw r3,0(r0)
    nextCycle();
    applyStimulus(32'h8C03_0000, 1'b0);
    expectVal("lw_m2reg", S_M2REG, 1);
    expectVal("lw_wreg", S_WREG, 1);
    expectVal("lw_fwda", S_FWDA, 0);
    expectVal("lw_exdes", S_EXDES, 2);

    // sub r4,r3,r0 right behind the load: stall
    nextCycle();
    applyStimulus(32'h0060_2022, 1'b0);
    expectVal("lu_wpcir", S_WPCIR, 1);
    expectVal("lu_em2reg", S_EM2REG, 1);
    expectVal("lu_exdes", S_EXDES, 3);
    expectVal("lu_aluc", S_ALUC, 1);
    expectVal("lu_wreg_unmasked", S_WREG, 1);
    expectVal("lu_branch", S_BRANCH, 0);

    // sub retried, bubble in EX, load in MEM
    nextCycle();
    MEDES  = 5'd3;
    MWREG  = 1'b1;
    MM2REG = 1'b1;
    expectVal("bub_ewreg", S_EWREG, 0);
    expectVal("bub_exdes", S_EXDES, 4);
    expectVal("bub_ealuc", S_EALUC, 1);
    expectVal("bub_fwda", S_FWDA, 3);
    expectVal("bub_wpcir", S_WPCIR, 0);

    // or r6,r5,r7 with ALU result for r5 in MEM
    nextCycle();
    applyStimulus(32'h00A7_3025, 1'b0);
    MEDES  = 5'd5;
    MM2REG = 1'b0;
    expectVal("or_fwda", S_FWDA, 2);
    expectVal("or_fwdb", S_FWDB, 0);
    expectVal("or_aluc", S_ALUC, 3);
    expectVal("or_ewreg", S_EWREG, 1);

    // and r8,r6,r6: EX match beats a MEM load match
    nextCycle();
    applyStimulus(32'h00C6_4024, 1'b0);
    MEDES  = 5'd6;
    MM2REG = 1'b1;
    expectVal("pri_fwda", S_FWDA, 1);
    expectVal("pri_fwdb", S_FWDB, 1);
    expectVal("and_aluc", S_ALUC, 2);

    // Branches
    nextCycle();
    MWREG  = 1'b0;
    MM2REG = 1'b0;
    applyStimulus(32'h1000_0003, 1'b1);
    expectVal("beq_taken", S_BRANCH, 1);
    expectVal("beq_wreg", S_WREG, 0);
    nextCycle();
    applyStimulus(32'h1000_0003, 1'b0);
    expectVal("beq_not_taken", S_BRANCH, 0);
    nextCycle();
    applyStimulus(32'h1400_0003, 1'b0);
    expectVal("bne_taken", S_BRANCH, 1);
    nextCycle();
    applyStimulus(32'h1400_0003, 1'b1);
    expectVal("bne_not_taken", S_BRANCH, 0);

    // j, jal, jr r31
    nextCycle();
    applyStimulus(32'h0800_0010, 1'b0);
    expectVal("j_jump", S_JUMP, 1);
    expectVal("j_branch", S_BRANCH, 1);
    expectVal("j_wreg", S_WREG, 0);
    expectVal("j_jal", S_JAL, 0);
    nextCycle();
    applyStimulus(32'h0C00_0010, 1'b0);
    expectVal("jal_jump", S_JUMP, 1);
    expectVal("jal_jal", S_JAL, 1);
    expectVal("jal_wreg", S_WREG, 1);
    nextCycle();
    applyStimulus(32'h03E0_0008, 1'b0);
    expectVal("jr_exdes", S_EXDES, 31);
    expectVal("jr_ewreg", S_EWREG, 1);
    expectVal("jr_fwda", S_FWDA, 1);
    expectVal("jr_jr", S_JR, 1);
    expectVal("jr_branch", S_BRANCH, 1);
    expectVal("jr_wreg", S_WREG, 0);

    // ALU ops: sra, slt, lui, ori
    nextCycle();
    applyStimulus(32'h0000_4803, 1'b0);
    expectVal("sra_shift", S_SHIFT, 1);
    expectVal("sra_aluc", S_ALUC, 8);
    expectVal("sra_wreg", S_WREG, 1);
    nextCycle();
    applyStimulus(32'h0000_502A, 1'b0);
    EXA = 32'd4;
    EXB = 32'h8000_0000;
    expectVal("sra_exalu", S_EXALU, 32'hF800_0000);
    expectVal("sra_eshift", S_ESHIFT, 1);
    expectVal("slt_aluc", S_ALUC, 9);
    nextCycle();
    applyStimulus(32'h3C0B_1234, 1'b0);
    EXA = 32'hFFFF_FFFF;
    EXB = 32'd1;
    expectVal("slt_exalu", S_EXALU, 1);
    expectVal("slt_ealuc", S_EALUC, 9);
    expectVal("lui_aluc", S_ALUC, 5);
    expectVal("lui_aluimm", S_ALUIMM, 1);
    nextCycle();
    applyStimulus(32'h340C_00FF, 1'b0);
    EXA = 32'd0;
    EXB = 32'h0000_1234;
    expectVal("lui_exalu", S_EXALU, 32'h1234_0000);
    expectVal("lui_ealuimm", S_EALUIMM, 1);
    expectVal("ori_sext", S_SEXT, 1);
    expectVal("ori_aluc", S_ALUC, 3);

    // sw r1,0(r0) then store into ID instruction, bubble, store into IF
    nextCycle();
    applyStimulus(32'hAC01_0000, 1'b0);
    EXA = 32'h0000_00F0;
    EXB = 32'h0000_000F;
    expectVal("ori_exalu", S_EXALU, 32'h0000_00FF);
    expectVal("sw_wmem", S_WMEM, 1);
    expectVal("sw_wreg", S_WREG, 0);
    expectVal("sw_regrt", S_REGRT, 0);
    nextCycle();
    EXA = 32'h0000_00FC;
    EXB = 32'd0;
    expectVal("smc_ewmem", S_EWMEM, 1);
    expectVal("smc_smc", S_SMC, 1);
    expectVal("smc_wpcir", S_WPCIR, 1);
    expectVal("smc_smc2", S_SMC2, 0);
    nextCycle();
    expectVal("smc_bubble_ewmem", S_EWMEM, 0);
    expectVal("smc_idle", S_SMC, 0);
    expectVal("smc_idle_wpcir", S_WPCIR, 0);
    nextCycle();
    applyStimulus(32'h0000_0000, 1'b0);
    EXA = 32'h0000_0100;
    expectVal("smc2_ewmem", S_EWMEM, 1);
    expectVal("smc2_smc2", S_SMC2, 1);
    expectVal("smc2_smc", S_SMC, 0);
    expectVal("smc2_wpcir", S_WPCIR, 0);

    // Mid-run reset with a lw in ID, then an undefined opcode
    nextCycle();
    reset = 1'b1;
    applyStimulus(32'h8C03_0000, 1'b0);
    EXA = 32'd3;
    EXB = 32'd4;
    nextCycle();
    reset = 1'b0;
    applyStimulus(32'hFC00_0000, 1'b0);
    expectVal("mrst_ewreg", S_EWREG, 0);
    expectVal("mrst_em2reg", S_EM2REG, 0);
    expectVal("mrst_ewmem", S_EWMEM, 0);
    expectVal("mrst_ealuimm", S_EALUIMM, 0);
    expectVal("mrst_eshift", S_ESHIFT, 0);
    expectVal("mrst_ealuc", S_EALUC, 0);
    expectVal("mrst_exdes", S_EXDES, 0);
    expectVal("mrst_exalu", S_EXALU, 7);
    expectVal("undef_wreg", S_WREG, 0);
    expectVal("undef_m2reg", S_M2REG, 0);
    expectVal("undef_wmem", S_WMEM, 0);
    expectVal("undef_aluimm", S_ALUIMM, 0);
    expectVal("undef_regrt", S_REGRT, 0);
    expectVal("undef_jump", S_JUMP, 0);
    expectVal("undef_aluc", S_ALUC, 0);
    expectVal("undef_branch", S_BRANCH, 0);
    nextCycle();
    expectVal("undef_ewreg", S_EWREG, 0);
    expectVal("undef_em2reg", S_EM2REG, 0);
    expectVal("undef_exdes", S_EXDES, 0);

    // Drain the scoreboard with a bounded wait
    for (int i = 0; i < 5 && scoreQ.size() > 0; i++) begin
      @(negedge clock);
      #1;
    end
    if (scoreQ.size() > 0) begin
      testsRun++;
      testsFailed++;
      $display("[TB] FAIL drain: %0d expectations left, expected 0", scoreQ.size());
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/ctrl_alu_unit.md
# ctrl_alu_unit

Decode, hazard and execute-control block of the 5-stage MIPS-subset pipeline. It decodes the ID-stage instruction and generates forwarding selects, load-use and self-modifying-code stalls, and branch/jump redirects. It holds the ID/EX control register and contains the EX-stage ALU. The datapath (register file, pipeline data registers, memory) sits outside and consumes these signals.

## Interface
Parameters: none.

Ports:
- clock  in  1  pipeline clock; all state updates on rising edge
- reset  in  1  synchronous, active-high; clears ID/EX control register
- IDIR  in  32  instruction in ID
- IDEQU  in  1  forwarded rs value == forwarded rt value
- IFPC, IDPC  in  32  PC of IF and ID instructions
- MEDES  in  5  MEM-stage destination register
- MWREG, MM2REG  in  1  MEM-stage writes-register / is-load
- EXA, EXB  in  32  EX operands, already muxed by datapath
- WREG, M2REG, WMEM, ALUIMM, SHIFT, SEXT, REGRT, JUMP, JR, JAL  out  1  decoded ID controls (combinational)
- ALUC  out  4  decoded ALU op
- FWDA, FWDB  out  2  rs/rt operand select: 00 regfile, 01 EXALU, 10 MEM ALU result, 11 MEM load data
- WPCIR  out  1  stall: hold PC and IF/ID
- BRANCH  out  1  redirect PC to branch/jump target
- SMC  out  1  EX store overwrites the ID instruction
- SMC2  out  1  EX store overwrites the IF instruction
- EXALU  out  32  ALU result
- EXDES  out  5  registered destination
- EWREG, EM2REG, EWMEM, EALUIMM, ESHIFT  out  1  registered controls
- EALUC  out  4  registered ALU op

## Operation
- Supported: R-type (op 0) funct add 20, sub 22, and 24, or 25, xor 26, slt 2A, sll 00, srl 02, sra 03, jr 08; addi 08, slti 0A, andi 0C, ori 0D, xori 0E, lui 0F, lw 23, sw 2B, beq 04, bne 05, j 02, jal 03 (hex). Any other encoding is a NOP: all controls 0.
- ALUC: 0 add, 1 sub, 2 and, 3 or, 4 xor, 5 lui (B<<16), 6 sll (B<<A[4:0]), 7 srl, 8 sra, 9 slt signed (1/0); codes 10–15 give 0. Result is 32-bit; add/sub wrap with no overflow trap.
- Decode controls:
  - ALUIMM=1 for I-type ALU, lw and sw.
  - SEXT=1 selects zero-extension; used only for andi/ori/xori.
  - REGRT=1 for I-type ALU and lw.
  - SHIFT=1 for sll/srl/sra; the datapath then uses zero-extended shamt as A.
  - M2REG=1 for lw; WMEM=1 for sw.
  - JAL forces destination 31 and ALU op add with B=0.
  - JUMP=1 for j/jal; JR=1 for jr.
- Destination = 31 if JAL, else rt if REGRT, else rd. WREG=0 when the destination is 0.
- Source usage:
  - rs: all except sll/srl/sra, j, jal, lui.
  - rt: R-type, sw, beq, bne.
- Forwarding, per used source s != 0:
  - 01 if EWREG & !EM2REG & EXDES==s;
  - else 11 if MWREG & MM2REG & MEDES==s;
  - else 10 if MWREG & !MM2REG & MEDES==s;
  - else 00. EX match has priority.
- Load-use stall: EWREG & EM2REG & EXDES!=0 & EXDES equals a used source → WPCIR=1.
- SMC: EWMEM & EXALU==IDPC → SMC=1 and WPCIR=1.
- SMC2: EWMEM & EXALU==IFPC → SMC2=1 (fetch takes store data).
- BRANCH = !WPCIR & ((beq & IDEQU) | (bne & !IDEQU) | JUMP | JR).
- Bubble: when WPCIR=1, the values loaded into the ID/EX register have WREG, M2REG and WMEM forced to 0. The combinational decoded outputs are not masked.

## Timing
- The decode, forwarding, stall, SMC and BRANCH outputs, and the ALU, are combinational and take effect in the same cycle.
- The ID/EX control register (EXDES, EWREG, EM2REG, EWMEM, EALUIMM, ESHIFT, EALUC) loads the decoded values every rising edge, with the bubble masking applied. It updates even during a stall.
- Reset, sampled on a rising edge, clears all registered outputs to 0; reset has priority over load.
- Reset mid-operation discards any in-flight EX instruction. EXALU then reflects EALUC=0 (add).

## Test plan
- addi r1,r0,5 then add r2,r1,r1 → FWDA=FWDB=01 in the add's ID cycle; EXA=EXB=5 with EALUC=0 → EXALU=10.
- lw r3,0(r0) then sub r4,r3,r0 → WPCIR=1 for one cycle, next EWREG=0; following cycle FWDA=11, WPCIR=0.
- beq with IDEQU=1, IDIR=0x1000_0003 → BRANCH=1; same with IDEQU=0 → BRANCH=0; bne inverse.
- ALU: sra with B=0x8000_0000, A=4 → 0xF800_0000; slt A=-1, B=1 → 1; lui B=0x1234 → 0x1234_0000.
- sw in EX (EWMEM=1) with EXALU==IDPC → SMC=1, WPCIR=1; with EXALU==IFPC → SMC2=1, SMC=0.
- After reset asserted for one edge, all E* outputs and EXDES read 0; an undefined opcode 0x3F decodes to all-zero controls.
